mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 102 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Sequencer that walks a select bus across an external N:1 mux, captures one
// bit per channel into a scan word, and holds it under a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; sel and data_out hold the last scan
// SCAN  | stepping sel, sampling mux_out on the last settle cycle of each channel
// DONE  | data_out complete, data_valid high until data_ready
module mux_scan_ctrl #(
    parameter int SEL_W  = 4,
    parameter int SETTLE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mux_out,
    input  logic                    data_ready,
    output logic [SEL_W-1:0]        sel,
    output logic                    busy,
    output logic [(2**SEL_W)-1:0]   data_out,
    output logic                    data_valid
);

    localparam int N = 2**SEL_W;
    localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
    localparam logic [SEL_W-1:0] SEL_LAST = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [3:0]       cnt_q;
    logic [N-1:0]     data_q;
    logic [N-1:0]     data_d;
    logic             busy_q;
    logic             valid_q;

    // Scan word with the currently selected channel replaced by the mux output.
    always_comb begin
        data_d        = data_q;
        data_d[sel_q] = mux_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SCAN;
                        sel_q   <= '0;
                        cnt_q   <= '0;
                        data_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (cnt_q == SETTLE_C) begin
                        data_q <= data_d;
                        cnt_q  <= '0;
                        // sel stays on the last channel rather than wrapping to 0
                        if (sel_q == SEL_LAST) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                        end else begin
                            sel_q <= sel_q + SEL_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (data_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = sel_q;
    assign busy       = busy_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: default instance plus a SETTLE=2 instance,
// each fed by a modelled 16:1 mux over a bench-held pattern.
module tb_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic        data_ready, data_ready2;
    logic [15:0] pat, pat2;
    logic        mux_out, mux_out2;
    logic [3:0]  sel, sel2;
    logic        busy, busy2;
    logic [15:0] data_out, data_out2;
    logic        data_valid, data_valid2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mux_out  = pat[sel];
    assign mux_out2 = pat2[sel2];

    mux_scan_ctrl #(.SEL_W(4), .SETTLE(0)) dut (
        .clk(clk), .rst(rst), .start(start), .mux_out(mux_out),
        .data_ready(data_ready), .sel(sel), .busy(busy),
        .data_out(data_out), .data_valid(data_valid)
    );

    mux_scan_ctrl #(.SEL_W(4), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mux_out(mux_out2),
        .data_ready(data_ready2), .sel(sel2), .busy(busy2),
        .data_out(data_out2), .data_valid(data_valid2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full default-instance scan with data_ready=1; expects valid at start+16.
    task automatic do_scan(input logic [15:0] exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("scan_busy", 32'(busy), 32'd1);
        check("scan_sel0", 32'(sel), 32'd0);
        check("scan_clear", 32'(data_out), 32'd0);
        check("scan_nvalid", 32'(data_valid), 32'd0);
        for (int k = 1; k < 16; k++) begin
            tick();
            check("scan_sel", 32'(sel), 32'(k));
            check("scan_nvalid", 32'(data_valid), 32'd0);
        end
        tick();
        check("done_valid", 32'(data_valid), 32'd1);
        check("done_data", 32'(data_out), 32'(exp));
        check("done_sel", 32'(sel), 32'd15);
        tick();
        check("idle_valid", 32'(data_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_data", 32'(data_out), 32'(exp));
        check("idle_sel", 32'(sel), 32'd15);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        data_ready = 1'b1; data_ready2 = 1'b1;
        pat = 16'hA5C3; pat2 = 16'h0001;
        tick();
        tick();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        rst = 1'b0;
        tick();

        // basic scan, ready already high on DONE entry
        do_scan(16'hA5C3);

        // SETTLE=2: each channel held 3 cycles, valid at start+48
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 3; j++) begin
                check("s2_sel", 32'(sel2), 32'(k));
                check("s2_nvalid", 32'(data_valid2), 32'd0);
                tick();
            end
        end
        check("s2_valid", 32'(data_valid2), 32'd1);
        check("s2_data", 32'(data_out2), 32'h0001);
        tick();
        check("s2_drop", 32'(data_valid2), 32'd0);
        check("s2_busy", 32'(busy2), 32'd0);

        // backpressure: hold DONE for 10 cycles
        data_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 17; k++) tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(data_valid), 32'd1);
            check("bp_data", 32'(data_out), 32'hA5C3);
            tick();
        end
        data_ready = 1'b1;
        tick();
        check("bp_rel_valid", 32'(data_valid), 32'd0);
        check("bp_rel_busy", 32'(busy), 32'd0);

        // start re-pulsed mid-scan and held through the DONE handshake
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 16; k++) begin
            tick();
            check("rs_sel", 32'(sel), 32'(k));
            if (k >= 5) start = 1'b1;
        end
        tick();
        check("rs_valid", 32'(data_valid), 32'd1);
        check("rs_data", 32'(data_out), 32'hA5C3);
        tick();
        check("rs_idle_busy", 32'(busy), 32'd0);
        check("rs_idle_valid", 32'(data_valid), 32'd0);
        start = 1'b0;
        tick();
        check("rs_no_restart", 32'(busy), 32'd0);
        check("rs_sel_hold", 32'(sel), 32'd15);

        // reset mid-scan at sel=9
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        check("ab_sel9", 32'(sel), 32'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ab_sel", 32'(sel), 32'd0);
        check("ab_data", 32'(data_out), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_valid", 32'(data_valid), 32'd0);
        tick();
        check("ab_stay_idle", 32'(busy), 32'd0);
        do_scan(16'hA5C3);

        // new patterns between scans; no carry-over
        pat = 16'hFFFF;
        do_scan(16'hFFFF);
        pat = 16'h1234;
        do_scan(16'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
